// File: rtl/debounce_sync.sv
// debounce_sync: conditions a raw asynchronous input into a clean,
// clock-aligned level. A multi-flop synchronizer feeds a 4-state FSM
// with a consecutive-sample counter; q only changes after
// DEBOUNCE_CYCLES synchronized samples in a row disagree with it.
// Also provides qbar plus one-cycle rise/fall pulses and a busy flag.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Counter only needs to hold 0..DEBOUNCE_CYCLES-1 inside a WAIT state.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Value of cnt on the sample that completes the debounce window
  // (i.e. cnt + 1 == DEBOUNCE_CYCLES), precomputed to avoid an adder
  // in the compare path.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_s;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   busy_q;

  // Synchronizer chain: stage 0 samples the raw input, each later stage
  // re-samples the previous one to resolve metastability.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage captures the asynchronous input.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            sync_q[gi] <= 1'b0;
          end else begin
            sync_q[gi] <= d;
          end
        end
      end else begin : g_rest
        // Later stages shift the sample one flop further along.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            sync_q[gi] <= 1'b0;
          end else begin
            sync_q[gi] <= sync_q[gi-1];
          end
        end
      end
    end
  endgenerate

  // Only the last synchronizer stage is ever seen by the FSM.
  assign d_s = sync_q[SYNC_STAGES-1];

  // Debounce FSM: counts consecutive samples that differ from the current
  // level, restarts on any sample that agrees with it, and registers all
  // outputs so downstream flops see glitch-free signals.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // Pulses default low; they are set only on the transition edge.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        IDLE_LOW: begin
          if (d_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // A single sample is enough: switch immediately.
              level_q <= 1'b1;
              rise_q  <= 1'b1;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE_HIGH;
            end else begin
              cnt_q   <= CNT_W'(1);
              busy_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end

        WAIT_HIGH: begin
          if (!d_s) begin
            // Input bounced back before the window completed: discard.
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE_LOW;
          end else if (cnt_q == CNT_LAST) begin
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE_HIGH;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            busy_q <= 1'b1;
          end
        end

        IDLE_HIGH: begin
          if (!d_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              level_q <= 1'b0;
              fall_q  <= 1'b1;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE_LOW;
            end else begin
              cnt_q   <= CNT_W'(1);
              busy_q  <= 1'b1;
              state_q <= WAIT_LOW;
            end
          end else begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end

        WAIT_LOW: begin
          if (d_s) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE_HIGH;
          end else if (cnt_q == CNT_LAST) begin
            level_q <= 1'b0;
            fall_q  <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE_LOW;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            busy_q <= 1'b1;
          end
        end

        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE_LOW;
        end
      endcase
    end
  end

  assign q    = level_q;
  assign qbar = ~level_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule
